imem_fetch_responder: RTL and testbench

Instruction-memory responder for the RISC-V CPU fetch port. It is loaded with a program through a byte-serial loader port. It then answers CPU fetch requests on `iaddr` with the 32-bit instruction word on `idata`, after a parameterised number of wait states. It sits between the CPU's fetch interface and the bench or boot loader, and replaces the flat instruction array used in CPU benches.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader.sv | 74 +++++++
 rtl/imem_fetch_responder.sv | 155 +++++++++++++++
 tb/tb_imem_fetch_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch responder.
//   state_t    : responder FSM states (LOAD, IDLE, WAIT, RESP)
//   NOP_INSN   : instruction returned for a failed fetch (addi x0,x0,0)
//   BYTE_LANES : bytes per 32-bit instruction word
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam int          BYTE_LANES = 4;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: assembles bytes little-endian into 32-bit words
// and issues one memory write per completed (or zero-padded final) word.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   active           : high while the responder is in its load phase
//   load_valid/byte/last, load_ready : loader byte handshake
//   wr_en, wr_addr, wr_data          : write strobe into the instruction memory
//   load_done        : pulses with the write that ends the load phase
module imem_loader
    import imem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 16,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          load_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          load_done
);

    logic [1:0]                    byte_cnt_reg;
    logic [AW-1:0]                 wptr_reg;
    // Lanes 0..2 of the word under construction; lane 3 is always the
    // incoming byte when a word completes, so it never needs storage.
    logic [8*(BYTE_LANES-1)-1:0]   buf_reg;
    logic                          accept;
    logic                          word_full;

    assign load_ready = active;
    assign accept     = active & load_valid;
    assign word_full  = (byte_cnt_reg == 2'd3);
    assign wr_en      = accept & (word_full | load_last);
    assign wr_addr    = wptr_reg;
    // Leaving on the last byte or on filling the final word; both may coincide.
    assign load_done  = wr_en & (load_last | (word_full & (wptr_reg == AW'(DEPTH_WORDS - 1))));

    // Word image for the current byte: earlier lanes from the buffer, the
    // current lane from the bus, later lanes zero (this is the padding for a
    // short final word).
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
            if (gi < BYTE_LANES - 1) begin : g_buffered
                assign wr_data[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? load_byte :
                                            (byte_cnt_reg >  2'(gi)) ? buf_reg[8*gi +: 8] :
                                                                       8'h00;
            end else begin : g_top
                assign wr_data[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? load_byte : 8'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_reg <= 2'd0;
            wptr_reg     <= '0;
            buf_reg      <= '0;
        end else if (accept) begin
            buf_reg      <= wr_data[8*(BYTE_LANES-1)-1:0];
            byte_cnt_reg <= wr_en ? 2'd0 : byte_cnt_reg + 2'd1;
            if (wr_en) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for a CPU fetch port. Loaded byte-serially,
// then answers one fetch at a time after WAIT_STATES extra cycles.
// Ports:
//   clk, reset                     : clock, synchronous active-low reset
//   req_valid, iaddr, req_ready    : fetch request (byte address)
//   rsp_valid, idata, rsp_err      : one-cycle response; idata/rsp_err held
//   load_valid, load_byte, load_last, load_ready : program loader port
//   loaded                         : high once loading has finished
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] iaddr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] idata,
    output logic        rsp_err,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic        loaded
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        state_reg, state_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic [AW-1:0] rd_idx_reg;
    logic          err_reg;
    logic [31:0]   idata_reg;
    logic          rsp_err_reg;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          load_active;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          load_done;

    logic          accept;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          fill;
    logic          rd_err;
    logic [AW-1:0] rd_idx;

    imem_loader #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .active     (load_active),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done)
    );

    // Memory contents survive reset; only the loader writes them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign accept  = (state_reg == IDLE) & req_valid;
    assign acc_err = (iaddr[1:0] != 2'b00) | (iaddr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx = iaddr[AW+1:2];

    // With no wait states the response is filled on the acceptance edge, so
    // the live request is used; otherwise the latched request is used.
    assign rd_idx = (state_reg == IDLE) ? acc_idx : rd_idx_reg;
    assign rd_err = (state_reg == IDLE) ? acc_err : err_reg;
    assign fill   = (state_next == RESP);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        load_active   = 1'b0;
        case (state_reg)
            LOAD: begin
                load_active = 1'b1;
                if (load_done) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= LOAD;
            wait_cnt_reg <= 4'd0;
            rd_idx_reg   <= '0;
            err_reg      <= 1'b0;
            idata_reg    <= 32'h0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                rd_idx_reg <= acc_idx;
                err_reg    <= acc_err;
            end
            if (fill) begin
                idata_reg   <= rd_err ? NOP_INSN : mem[rd_idx];
                rsp_err_reg <= rd_err;
            end
        end
    end

    assign idata   = idata_reg;
    assign rsp_err = rsp_err_reg;
    assign loaded  = (state_reg != LOAD);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: two responders (0 and 3 wait states) share every input and
// are checked side by side against hand-computed values.
module tb_imem_fetch_responder;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [31:0] addr;
        bit          hold;
        logic [31:0] data;
        logic        err;
    } fetch_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h0;
    logic        load_last = 1'b0;

    logic        req_ready0, rsp_valid0, rsp_err0, load_ready0, loaded0;
    logic [31:0] idata0;
    logic        req_ready3, rsp_valid3, rsp_err3, load_ready3, loaded3;
    logic [31:0] idata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .iaddr(iaddr),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .idata(idata0), .rsp_err(rsp_err0),
        .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready0), .loaded(loaded0)
    );

    imem_fetch_responder #(.DEPTH_WORDS(16), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .iaddr(iaddr),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .idata(idata3), .rsp_err(rsp_err3),
        .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready3), .loaded(loaded3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream bytes through the loader; exp_done says whether the load phase
    // must be over after the final byte.
    task automatic load_bytes(input string tag, input byte_q_t bytes, input bit with_last,
                              input bit exp_done);
        chk({tag, " load_ready0"}, 32'(load_ready0), 32'd1);
        chk({tag, " load_ready3"}, 32'(load_ready3), 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == bytes.size() - 1) begin
                chk({tag, " loaded before last byte"}, 32'(loaded0 | loaded3), 32'd0);
            end
            load_valid = 1'b1;
            load_byte  = bytes[i];
            load_last  = with_last && (i == bytes.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk({tag, " loaded0 after"}, 32'(loaded0), 32'(exp_done));
        chk({tag, " loaded3 after"}, 32'(loaded3), 32'(exp_done));
        chk({tag, " load_ready3 after"}, 32'(load_ready3), 32'(!exp_done));
    endtask

    // One fetch on both responders; records first response of each.
    task automatic fetch(input string tag, input fetch_vec_t v);
        int          lat0, lat3, pulses3;
        logic [31:0] d0, d3;
        logic        e0, e3;
        lat0 = 0; lat3 = 0; pulses3 = 0;
        d0 = 32'h0; d3 = 32'h0; e0 = 1'b0; e3 = 1'b0;
        chk({tag, " req_ready both idle"}, 32'(req_ready0 & req_ready3), 32'd1);
        req_valid = 1'b1;
        iaddr     = v.addr;
        tick();
        iaddr = 32'hFFFF_FFFF;
        if (!v.hold) req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (rsp_valid0 && lat0 == 0) begin
                lat0 = c; d0 = idata0; e0 = rsp_err0;
            end
            if (rsp_valid3) begin
                pulses3++;
                if (lat3 == 0) begin
                    lat3 = c; d3 = idata3; e3 = rsp_err3;
                end
            end
            if (!v.hold && c == 1) chk({tag, " req_ready0 low in RESP"}, 32'(req_ready0), 32'd0);
            if (!v.hold && c == 2) chk({tag, " req_ready0 back"}, 32'(req_ready0), 32'd1);
            if (v.hold && c <= 4) chk({tag, " req_ready3 low while busy"}, 32'(req_ready3), 32'd0);
            if (v.hold && c == 5) begin
                chk({tag, " req_ready3 back in IDLE"}, 32'(req_ready3), 32'd1);
                req_valid = 1'b0;
            end
            tick();
        end
        chk({tag, " latency ws0"}, 32'(lat0), 32'd1);
        chk({tag, " latency ws3"}, 32'(lat3), 32'd4);
        chk({tag, " idata ws0"}, d0, v.data);
        chk({tag, " rsp_err ws0"}, 32'(e0), 32'(v.err));
        chk({tag, " idata ws3"}, d3, v.data);
        chk({tag, " rsp_err ws3"}, 32'(e3), 32'(v.err));
        chk({tag, " ws3 single response"}, 32'(pulses3), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t    prog8;
        byte_q_t    prog5;
        byte_q_t    part2;
        byte_q_t    prog64;
        fetch_vec_t vecs[5];
        int         pulses;

        prog8  = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        prog5  = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hAB};
        part2  = '{8'h55, 8'h66};
        for (int i = 0; i < 64; i++) prog64.push_back(8'(i));

        vecs[0] = '{addr: 32'd4,  hold: 1'b0, data: 32'h0020_0113, err: 1'b0};
        vecs[1] = '{addr: 32'd0,  hold: 1'b1, data: 32'h0010_0093, err: 1'b0};
        vecs[2] = '{addr: 32'd2,  hold: 1'b0, data: 32'h0000_0013, err: 1'b1};
        vecs[3] = '{addr: 32'd64, hold: 1'b0, data: 32'h0000_0013, err: 1'b1};
        vecs[4] = '{addr: 32'd0,  hold: 1'b0, data: 32'h0010_0093, err: 1'b0};

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        chk("reset load_ready3", 32'(load_ready3), 32'd1);
        chk("reset loaded3", 32'(loaded3), 32'd0);
        chk("reset req_ready3", 32'(req_ready3), 32'd0);
        chk("reset rsp_valid3", 32'(rsp_valid3), 32'd0);
        chk("reset rsp_err3", 32'(rsp_err3), 32'd0);
        chk("reset idata3", idata3, 32'h0);
        chk("reset idata0", idata0, 32'h0);
        chk("reset loaded0", 32'(loaded0), 32'd0);
        reset = 1'b1;

        load_bytes("load8", prog8, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            fetch($sformatf("fetch%0d", i), vecs[i]);
        end

        // Reset while the 3-wait-state responder is in WAIT
        req_valid = 1'b1;
        iaddr     = 32'd0;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid3) pulses++;
            if (c == 0) begin
                chk("rst-in-wait loaded3", 32'(loaded3), 32'd0);
                chk("rst-in-wait load_ready3", 32'(load_ready3), 32'd1);
                chk("rst-in-wait loaded0", 32'(loaded0), 32'd0);
            end
            tick();
        end
        chk("rst-in-wait no response", 32'(pulses), 32'd0);

        load_bytes("reload8", prog8, 1'b1, 1'b1);
        fetch("reload fetch4", vecs[0]);
        fetch("reload fetch0", vecs[4]);

        // Partial load interrupted by reset, then a short padded program
        do_reset();
        load_bytes("part2", part2, 1'b0, 1'b0);
        do_reset();
        load_bytes("load5", prog5, 1'b1, 1'b1);
        fetch("pad fetch4", '{addr: 32'd4, hold: 1'b0, data: 32'h0000_00AB, err: 1'b0});
        fetch("pad fetch0", '{addr: 32'd0, hold: 1'b0, data: 32'h0010_0093, err: 1'b0});

        // Full-depth load with no last marker, then loader bytes are ignored
        do_reset();
        load_bytes("load64", prog64, 1'b0, 1'b1);
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        load_last  = 1'b1;
        tick();
        chk("ignored byte load_ready0", 32'(load_ready0), 32'd0);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch("full fetch0",  '{addr: 32'd0,  hold: 1'b0, data: 32'h0302_0100, err: 1'b0});
        fetch("full fetch60", '{addr: 32'd60, hold: 1'b0, data: 32'h3F3E_3D3C, err: 1'b0});
        fetch("full fetch28", '{addr: 32'd28, hold: 1'b0, data: 32'h1F1E_1D1C, err: 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
